// File: rtl/instr_fetch.sv
// WISC-S15 fetch front end: PC, one-outstanding imem req/rdy, 2-entry instruction FIFO to decode.
// instr_valid rises the cycle after imem_rdy; requests stop while the FIFO would be full or after HALT.
module instr_fetch #(
  parameter int                 ADDR_W   = 16,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_rdy,
  input  logic [15:0]       imem_rdata,
  output logic              instr_valid,
  output logic [15:0]       instr,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              instr_ready,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              halted
);

  localparam logic [15:0] HALT_WORD = 16'hFFFF;

  typedef enum logic [1:0] {S_FETCH, S_WAIT, S_FLUSH, S_STOP} state_t;

  typedef struct packed {
    logic [15:0]       word;
    logic [ADDR_W-1:0] pc;
  } entry_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic              req_q, req_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        cnt_q, cnt_d;
  entry_t            slot0_q, slot0_d;
  entry_t            slot1_q, slot1_d;
  logic              halted_q, halted_d;

  logic              pop, resp, redir, push, live, room, stale_pending;
  logic [ADDR_W-1:0] addr_inc;
  entry_t            new_e;

  always_comb begin
    pop           = (cnt_q != 2'd0) && instr_ready;
    resp          = req_q && imem_rdy;
    redir         = redirect && !halted_q;
    stale_pending = req_q && !imem_rdy;
    live          = (state_q == S_FETCH) || (state_q == S_WAIT);
    push          = resp && live && !redir;
    addr_inc      = addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
    new_e.word    = imem_rdata;
    new_e.pc      = addr_q;
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state
  always_comb begin
    state_d = state_q;
    if (redir) begin
      state_d = stale_pending ? S_FLUSH : S_FETCH;
    end else begin
      case (state_q)
        S_FETCH, S_WAIT: begin
          if (resp)       state_d = (imem_rdata == HALT_WORD) ? S_STOP : S_FETCH;
          else if (req_q) state_d = S_WAIT;
        end
        S_FLUSH: if (resp) state_d = S_FETCH;
        S_STOP:  state_d = S_STOP;
        default: state_d = S_FETCH;
      endcase
    end
  end

  // FIFO: slot0 is always the head, so the outputs come straight from flops
  always_comb begin
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    cnt_d   = cnt_q;
    if (redir) begin
      cnt_d = 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (cnt_q == 2'd0) slot0_d = new_e;
          else               slot1_d = new_e;
          cnt_d = cnt_q + 2'd1;
        end
        2'b01: begin
          slot0_d = slot1_q;
          cnt_d   = cnt_q - 2'd1;
        end
        2'b11: begin
          if (cnt_q == 2'd1) begin
            slot0_d = new_e;
          end else begin
            slot0_d = slot1_q;
            slot1_d = new_e;
          end
        end
        default: ;
      endcase
    end
  end

  assign room = (cnt_d != 2'd2);

  // Request issue; the address only moves once the previous request was answered
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    req_d      = req_q;
    addr_d     = addr_q;
    halted_d   = halted_q || (pop && (slot0_q.word == HALT_WORD));
    if (redir) begin
      fetch_pc_d = redirect_pc;
      if (!stale_pending) begin
        req_d  = 1'b1;
        addr_d = redirect_pc;
      end
    end else begin
      case (state_q)
        S_FETCH, S_WAIT: begin
          if (resp) begin
            fetch_pc_d = addr_inc;
            req_d      = (imem_rdata != HALT_WORD) && room;
            addr_d     = addr_inc;
          end else if (!req_q) begin
            req_d  = room;
            addr_d = fetch_pc_q;
          end
        end
        S_FLUSH: begin
          if (resp) begin
            req_d  = room;
            addr_d = fetch_pc_q;
          end
        end
        S_STOP:  req_d = 1'b0;
        default: req_d = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      req_q      <= 1'b0;
      addr_q     <= RESET_PC;
      cnt_q      <= 2'd0;
      slot0_q    <= '0;
      slot1_q    <= '0;
      halted_q   <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      req_q      <= req_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      slot0_q    <= slot0_d;
      slot1_q    <= slot1_d;
      halted_q   <= halted_d;
    end
  end

  // Outputs
  always_comb begin
    imem_req    = req_q;
    imem_addr   = addr_q;
    instr_valid = (cnt_q != 2'd0);
    instr       = slot0_q.word;
    instr_pc    = slot0_q.pc;
    halted      = halted_q;
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: table of per-cycle vectors for streaming/backpressure,
// plus directed sequences for redirect, wrong-path HALT, wrap/halt and async reset.
module tb_instr_fetch;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_rdy;
  logic [15:0] imem_rdata;
  logic        instr_valid;
  logic [15:0] instr;
  logic [15:0] instr_pc;
  logic        instr_ready;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        halted;

  int tests = 0;
  int fails = 0;

  // memory model state
  int          lat = 0;
  int          mem_n = 0;
  logic        prev_rdy = 1'b0;
  logic        halt_en = 1'b0;
  logic [15:0] halt_addr = 16'h0;

  instr_fetch #(.ADDR_W(16), .RESET_PC(16'h0000)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdy(imem_rdy), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
    .instr_ready(instr_ready),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .halted(halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst_b;
    logic        rdy;
    logic        vld;
    logic [15:0] pc;
    logic [15:0] ins;
    logic        req;
    logic [15:0] addr;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs[NV];

  function automatic vec_t mk(input logic rb, input logic r, input logic v,
                              input logic [15:0] p, input logic [15:0] i,
                              input logic q, input logic [15:0] a);
    vec_t t;
    t.rst_b = rb; t.rdy = r; t.vld = v; t.pc = p; t.ins = i; t.req = q; t.addr = a;
    return t;
  endfunction

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    if (halt_en && a == halt_addr) return 16'hFFFF;
    return a + 16'h1000;
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic mem_update();
    if (!imem_req) begin
      mem_n    = 0;
      imem_rdy = 1'b0;
    end else begin
      if (prev_rdy) mem_n = 0;
      imem_rdy = (mem_n >= lat);
      mem_n++;
    end
    prev_rdy   = imem_rdy;
    imem_rdata = mem_word(imem_addr);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    mem_update();
  endtask

  task automatic do_reset();
    rst         = 1'b1;
    instr_ready = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 16'h0;
    imem_rdy    = 1'b0;
    mem_n       = 0;
    prev_rdy    = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    mem_update();
  endtask

  task automatic wait_req(input logic [15:0] a, input string nm);
    int n = 0;
    while (!(imem_req && imem_addr == a) && n < 60) begin
      step();
      n++;
    end
    chk1(nm, imem_req && (imem_addr == a), 1'b1);
  endtask

  task automatic wait_vld(input string nm);
    int n = 0;
    while (!instr_valid && n < 60) begin
      step();
      n++;
    end
    chk1(nm, instr_valid, 1'b1);
  endtask

  task automatic chk_reset_vals(input string nm);
    chk1({nm, " imem_req"}, imem_req, 1'b0);
    chk({nm, " imem_addr"}, imem_addr, 16'h0000);
    chk1({nm, " instr_valid"}, instr_valid, 1'b0);
    chk({nm, " instr"}, instr, 16'h0000);
    chk({nm, " instr_pc"}, instr_pc, 16'h0000);
    chk1({nm, " halted"}, halted, 1'b0);
  endtask

  initial begin
    rst = 1'b1; instr_ready = 1'b0; redirect = 1'b0; redirect_pc = 16'h0;
    imem_rdy = 1'b0; imem_rdata = 16'h0;

    // streaming, zero-wait, decode always ready
    vecs[0]  = mk(1, 1, 0, 16'h0, 16'h0,    0, 16'h0);
    vecs[1]  = mk(0, 1, 0, 16'h0, 16'h0,    1, 16'h0);
    vecs[2]  = mk(0, 1, 1, 16'h0, 16'h1000, 1, 16'h1);
    vecs[3]  = mk(0, 1, 1, 16'h1, 16'h1001, 1, 16'h2);
    vecs[4]  = mk(0, 1, 1, 16'h2, 16'h1002, 1, 16'h3);
    vecs[5]  = mk(0, 1, 1, 16'h3, 16'h1003, 1, 16'h4);
    // backpressure: decode stalls while pc 0 and pc 1 fill the FIFO
    vecs[6]  = mk(1, 0, 0, 16'h0, 16'h0,    0, 16'h0);
    vecs[7]  = mk(0, 0, 0, 16'h0, 16'h0,    1, 16'h0);
    vecs[8]  = mk(0, 0, 1, 16'h0, 16'h1000, 1, 16'h1);
    vecs[9]  = mk(0, 0, 1, 16'h0, 16'h1000, 0, 16'h0);
    vecs[10] = mk(0, 0, 1, 16'h0, 16'h1000, 0, 16'h0);
    vecs[11] = mk(0, 0, 1, 16'h0, 16'h1000, 0, 16'h0);
    vecs[12] = mk(0, 0, 1, 16'h0, 16'h1000, 0, 16'h0);
    vecs[13] = mk(0, 1, 1, 16'h0, 16'h1000, 0, 16'h0);
    vecs[14] = mk(0, 1, 1, 16'h1, 16'h1001, 1, 16'h2);
    vecs[15] = mk(0, 1, 1, 16'h2, 16'h1002, 1, 16'h3);
    vecs[16] = mk(0, 1, 1, 16'h3, 16'h1003, 1, 16'h4);

    #3;
    chk_reset_vals("reset");

    lat = 0;
    for (int i = 0; i < NV; i++) begin
      if (vecs[i].rst_b) do_reset();
      chk1($sformatf("row%0d valid", i), instr_valid, vecs[i].vld);
      if (vecs[i].vld) begin
        chk($sformatf("row%0d instr_pc", i), instr_pc, vecs[i].pc);
        chk($sformatf("row%0d instr", i), instr, vecs[i].ins);
      end
      chk1($sformatf("row%0d imem_req", i), imem_req, vecs[i].req);
      if (vecs[i].req) chk($sformatf("row%0d imem_addr", i), imem_addr, vecs[i].addr);
      instr_ready = vecs[i].rdy;
      step();
    end

    // redirect while a latency-3 request to 0x0002 is waiting
    do_reset();
    lat = 3;
    instr_ready = 1'b1;
    wait_req(16'h0002, "rw reach req 2");
    step();
    chk1("rw wait req", imem_req, 1'b1);
    chk("rw wait addr", imem_addr, 16'h0002);
    redirect = 1'b1; redirect_pc = 16'h0040;
    step();
    redirect = 1'b0;
    chk1("rw flush valid", instr_valid, 1'b0);
    chk("rw flush addr held", imem_addr, 16'h0002);
    begin
      int n = 0;
      while (!imem_rdy && n < 20) begin step(); n++; end
    end
    chk1("rw stale rdy", imem_rdy, 1'b1);
    step();
    chk1("rw new req", imem_req, 1'b1);
    chk("rw new addr", imem_addr, 16'h0040);
    wait_vld("rw new valid");
    chk("rw first pc", instr_pc, 16'h0040);
    chk("rw first instr", instr, 16'h1040);

    // wrong-path HALT fetched at 0x0003, redirect taken as pc 0x0002 is accepted
    do_reset();
    lat = 0; halt_en = 1'b1; halt_addr = 16'h0003;
    instr_ready = 1'b1;
    wait_req(16'h0003, "wp reach req 3");
    instr_ready = 1'b0;
    step();
    chk("wp head pc", instr_pc, 16'h0002);
    chk1("wp stopped req", imem_req, 1'b0);
    instr_ready = 1'b1; redirect = 1'b1; redirect_pc = 16'h0010;
    step();
    redirect = 1'b0;
    chk1("wp flushed valid", instr_valid, 1'b0);
    chk1("wp resume req", imem_req, 1'b1);
    chk("wp resume addr", imem_addr, 16'h0010);
    chk1("wp halted", halted, 1'b0);
    step();
    chk("wp next pc", instr_pc, 16'h0010);
    chk("wp next instr", instr, 16'h1010);
    step();
    chk1("wp halted later", halted, 1'b0);

    // PC wrap from 0xFFFE and a real HALT at 0x0000
    do_reset();
    lat = 0; halt_en = 1'b0;
    instr_ready = 1'b1;
    wait_req(16'h0002, "hw reach req 2");
    redirect = 1'b1; redirect_pc = 16'hFFFE;
    halt_en = 1'b1; halt_addr = 16'h0000;
    step();
    redirect = 1'b0;
    chk("hw addr fffe", imem_addr, 16'hFFFE);
    step();
    chk("hw pc fffe", instr_pc, 16'hFFFE);
    chk("hw instr fffe", instr, 16'h0FFE);
    chk("hw addr ffff", imem_addr, 16'hFFFF);
    step();
    chk("hw pc ffff", instr_pc, 16'hFFFF);
    chk("hw instr ffff", instr, 16'h0FFF);
    chk("hw addr wrap", imem_addr, 16'h0000);
    step();
    chk("hw halt pc", instr_pc, 16'h0000);
    chk("hw halt instr", instr, 16'hFFFF);
    chk1("hw not yet halted", halted, 1'b0);
    chk1("hw stop req", imem_req, 1'b0);
    step();
    chk1("hw halted", halted, 1'b1);
    chk1("hw drained", instr_valid, 1'b0);
    redirect = 1'b1; redirect_pc = 16'h0020;
    step();
    redirect = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk1($sformatf("hw ignore redirect req%0d", k), imem_req, 1'b0);
      chk1($sformatf("hw sticky halted%0d", k), halted, 1'b1);
      step();
    end
    #2 rst = 1'b1;
    #1;
    chk1("hw async reset halted", halted, 1'b0);

    // asynchronous reset while waiting on a request to 0x0005
    halt_en = 1'b0;
    do_reset();
    lat = 2;
    instr_ready = 1'b1;
    wait_req(16'h0005, "rs reach req 5");
    step();
    chk1("rs waiting req", imem_req, 1'b1);
    chk("rs waiting addr", imem_addr, 16'h0005);
    #2 rst = 1'b1;
    #1;
    chk_reset_vals("rs mid-wait");
    do_reset();
    chk1("rs cycle0 req", imem_req, 1'b0);
    step();
    chk1("rs first req", imem_req, 1'b1);
    chk("rs first addr", imem_addr, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
